// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a synchronous FIFO (registered read data) and
// re-presents the words on a valid/ready stream through a 3-entry skid buffer.
// Optional statistics (delivered-word counter, sticky underflow flag) are
// built only when FIFO_READER_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [STAT_WIDTH-1:0] delivered_cnt,
  output logic                  proto_err
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [FIFO_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      buf_cnt;
  logic [CNT_W-1:0]      buf_cnt_next;
  logic                  inflight;
  logic                  inflight_next;
  logic [CNT_W:0]        outstanding;
  logic                  capture;
  logic                  pop;

  // Circular pointer increment wrapping after the last entry
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Read credit counts words already buffered plus the one still in flight
  assign outstanding = {1'b0, buf_cnt} + {{CNT_W{1'b0}}, inflight};
  assign fifo_rd_en  = !rst && enable && !fifo_empty && !flush &&
                       (outstanding < (CNT_W+1)'(DEPTH));

  assign m_valid = (buf_cnt != '0);
  assign m_data  = mem[head];
  assign pop     = m_valid && m_ready;
  assign capture = inflight && !flush;

  // Next occupancy of the skid buffer and the in-flight tracker
  always_comb begin
    buf_cnt_next  = buf_cnt;
    inflight_next = fifo_rd_en;
    if (flush) begin
      buf_cnt_next  = '0;
      inflight_next = 1'b0;
    end else begin
      case ({capture, pop})
        2'b10:   buf_cnt_next = buf_cnt + CNT_W'(1);
        2'b01:   buf_cnt_next = buf_cnt - CNT_W'(1);
        default: buf_cnt_next = buf_cnt;
      endcase
    end
  end

  // Skid buffer storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      head     <= '0;
      tail     <= '0;
      buf_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      buf_cnt  <= buf_cnt_next;
      inflight <= inflight_next;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (capture) begin
          mem[tail] <= fifo_data_out;
          tail      <= ptr_inc(tail);
        end
        if (pop) head <= ptr_inc(head);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: flush dominates, otherwise follow occupancy
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_FLUSH: state_next = ST_IDLE;
        default:  state_next = ((buf_cnt_next == '0) && !inflight_next) ? ST_IDLE : ST_STREAM;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Saturating delivered-word counter and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delivered_cnt <= '0;
      proto_err     <= 1'b0;
    end else begin
      if (pop && (delivered_cnt != '1)) delivered_cnt <= delivered_cnt + STAT_WIDTH'(1);
      if (fifo_underflow) proto_err <= 1'b1;
    end
  end
`else
  // Statistics not built: outputs tied off
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
  assign delivered_cnt    = '0;
  assign proto_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a FIFO model and a scoreboard of
// expected stream words. Define FIFO_READER_STATS_EN to exercise statistics.
module tb_fifo_stream_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_rd_en;
  logic          enable;
  logic          flush;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready;
  logic [SW-1:0] delivered_cnt;
  logic          proto_err;

  logic [W-1:0]  fmem [256];
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic [W-1:0]  exp_q [$];

  int            errs;
  int            checks;
  int            hs_total;
  int unsigned   deliv_model;
  logic          s_valid;
  logic          s_rd;
  logic [W-1:0]  s_data;
  logic          hs;
  logic          rd_pend;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  fifo_stream_reader #(.FIFO_WIDTH(W), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .enable(enable),
    .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .delivered_cnt(delivered_cnt), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    fmem[wr_ptr] = d;
    wr_ptr       = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  // One clock: sample at negedge, score handshakes, then model the FIFO read
  task automatic tick();
    @(negedge clk);
    s_valid = m_valid;
    s_data  = m_data;
    s_rd    = fifo_rd_en;
    hs      = !rst && m_valid && m_ready;
    rd_pend = fifo_rd_en && !rst;
    if (hs) begin
      hs_total++;
      if (deliv_model != 32'hFFFF) deliv_model++;
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL sb_extra observed=%h expected=none", s_data);
      end else begin
        check("sb_data", 32'(s_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    if (rd_pend) begin
      fifo_data_out = fmem[rd_ptr];
      rd_ptr        = rd_ptr + 8'd1;
    end
  endtask

  initial begin
    int first;
    int last;
    int cnt;
    int hs0;
    int bad;
    int vcnt;
    errs = 0; checks = 0; hs_total = 0; deliv_model = 0;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    wr_ptr = '0; rd_ptr = '0; fifo_data_out = '0; rd_pend = 1'b0;

    // Reset state
    #12;
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_delivered", 32'(delivered_cnt), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;

    // Full-rate stream of 8 preloaded words
    for (int i = 0; i < 8; i++) push_word(W'(16'hA001 + i));
    first = 0; last = 0; cnt = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (hs) begin
        if (first == 0) first = t;
        last = t;
        cnt++;
      end
    end
    check("t1_first_valid_tick", 32'(first), 32'd3);
    check("t1_last_valid_tick", 32'(last), 32'd10);
    check("t1_words", 32'(cnt), 32'd8);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_READER_STATS_EN
    check("t1_delivered", 32'(delivered_cnt), 32'd8);
`else
    check("t1_delivered", 32'(delivered_cnt), 32'd0);
`endif

    // Back-pressure: only 3 reads outstanding, head word held stable
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(W'(16'hA001 + i));
    cnt = 0; bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (s_rd) cnt++;
      if (s_valid && (s_data != 16'hA001)) bad++;
    end
    check("t2_reads", 32'(cnt), 32'd3);
    check("t2_valid", 32'(s_valid), 32'd1);
    check("t2_data", 32'(s_data), 32'hA001);
    check("t2_rd_en_idle", 32'(s_rd), 32'd0);
    check("t2_data_unstable", 32'(bad), 32'd0);
    m_ready = 1'b1;
    hs0 = hs_total;
    for (int t = 0; t < 15; t++) tick();
    check("t2_drained", 32'(hs_total - hs0), 32'd8);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty FIFO: never read, never valid
    cnt = 0; vcnt = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (s_rd) cnt++;
      if (s_valid) vcnt++;
    end
    check("t3_reads", 32'(cnt), 32'd0);
    check("t3_valid", 32'(vcnt), 32'd0);
    check("t3_proto_err", 32'(proto_err), 32'd0);

    // Flush with 2 buffered and 1 in flight discards all three
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(W'(16'hC001 + i));
    for (int t = 0; t < 3; t++) tick();
    check("t4_pre_buf_cnt", 32'(dut.buf_cnt), 32'd2);
    check("t4_pre_inflight", 32'(dut.inflight), 32'd1);
    flush = 1'b1;
    tick();
    check("t4_flush_rd_en", 32'(s_rd), 32'd0);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    tick();
    check("t4_post_valid", 32'(s_valid), 32'd0);
    check("t4_post_buf_cnt", 32'(dut.buf_cnt), 32'd0);
    m_ready = 1'b1;
    hs0 = hs_total;
    for (int t = 0; t < 15; t++) tick();
    check("t4_drained", 32'(hs_total - hs0), 32'd5);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with 3 words buffered
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(W'(16'hD001 + i));
    for (int t = 0; t < 4; t++) tick();
    check("t5_pre_buf_cnt", 32'(dut.buf_cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(m_valid), 32'd0);
    check("t5_rst_data", 32'(m_data), 32'd0);
    check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t5_rst_delivered", 32'(delivered_cnt), 32'd0);
    check("t5_rst_proto_err", 32'(proto_err), 32'd0);
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    deliv_model = 0;
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    hs0 = hs_total;
    for (int t = 0; t < 15; t++) tick();
    check("t5_drained", 32'(hs_total - hs0), 32'd5);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Underflow report
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    tick();
`ifdef FIFO_READER_STATS_EN
    check("t6_proto_err_set", 32'(proto_err), 32'd1);
    for (int t = 0; t < 3; t++) tick();
    check("t6_proto_err_sticky", 32'(proto_err), 32'd1);

    // Long stream saturates the delivered counter
    for (int i = 0; i < 70010; i++) begin
      if (8'(wr_ptr - rd_ptr) < 8'd64) push_word(W'(i));
      tick();
    end
    for (int t = 0; t < 80; t++) tick();
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t6_delivered_model", 32'(delivered_cnt), 32'(SW'(deliv_model)));
    check("t6_delivered_sat", 32'(delivered_cnt), 32'hFFFF);
    check("t6_proto_err_still", 32'(proto_err), 32'd1);
`else
    check("t6_proto_err_tied", 32'(proto_err), 32'd0);
    check("t6_delivered_tied", 32'(delivered_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
